// File: rtl/ysyx_24100005_mem_pkg.sv
// rtl/ysyx_24100005_mem_pkg.sv - shared types and widths for the IFU/LSU memory arbiter
package ysyx_24100005_mem_pkg;
   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_MASK_W = MEM_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;
endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// rtl/ysyx_24100005_rr_arb2.sv - two-input round-robin grant with registered last winner
module ysyx_24100005_rr_arb2
   import ysyx_24100005_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);
   owner_t r_last_grant;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (r_last_grant == OWN_IFU) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWN_IFU;
      end else if (accept && (|grant)) begin
         r_last_grant <= grant[1] ? OWN_LSU : OWN_IFU;
      end
   end
endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// rtl/ysyx_24100005_mem_arbiter.sv - shares one memory port between IFU and LSU,
// one outstanding transaction, with a response watchdog.
module ysyx_24100005_mem_arbiter
   import ysyx_24100005_mem_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_resp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           r_state;
   owner_t           r_owner;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       w_req;
   logic [1:0]       w_grant;
   logic             w_accept;
   logic             w_timeout;
   logic             w_done;

   assign w_req     = {lsu_req_valid, ifu_req_valid};
   assign w_accept  = !rst && (r_state == IDLE) && (|w_req);
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_done    = mem_resp_valid || w_timeout;

   ysyx_24100005_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (w_req),
      .accept (w_accept),
      .grant  (w_grant)
   );

   assign ifu_req_ready = w_accept & w_grant[0];
   assign lsu_req_ready = w_accept & w_grant[1];
   assign mem_req_valid = (r_state == REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_owner        <= OWN_IFU;
         r_cnt          <= '0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_resp_err   <= 1'b0;
         ifu_rdata      <= '0;
         lsu_resp_valid <= 1'b0;
         lsu_resp_err   <= 1'b0;
         lsu_rdata      <= '0;
      end else begin
         ifu_resp_valid <= 1'b0;
         ifu_resp_err   <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_resp_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= REQ;
                  if (w_grant[1]) begin
                     r_owner   <= OWN_LSU;
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     r_owner   <= OWN_IFU;
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  r_state <= RESP;
                  r_cnt   <= '0;
               end
            end
            RESP: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // A real response wins over a watchdog expiring in the same cycle.
               if (w_done) begin
                  r_state <= IDLE;
                  if (r_owner == OWN_LSU) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_resp_err   <= !mem_resp_valid;
                     lsu_rdata      <= mem_resp_valid ? mem_rdata : '0;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_resp_err   <= !mem_resp_valid;
                     ifu_rdata      <= mem_resp_valid ? mem_rdata : '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
